// File: rtl/imem_uart_loader_if.sv
// -----------------------------------------------------------------------------
// imem_uart_loader_if
// Write port of the 512x16 instruction RAM as driven by the serial loader.
//   imem_we    : one-cycle write strobe per instruction word
//   imem_addr  : 9-bit word address, stable while imem_we is high
//   imem_wdata : 16-bit instruction word, stable while imem_we is high
// Modports: master (loader side, drives), slave (RAM side, receives).
// -----------------------------------------------------------------------------
interface imem_wr_if;
  logic        imem_we;
  logic [8:0]  imem_addr;
  logic [15:0] imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// -----------------------------------------------------------------------------
// imem_uart_loader
// Serial program loader for the instruction RAM. Receives an 8N1 UART frame
//   0x55, count_hi, count_lo, N x (data_hi, data_lo) [, checksum]
// and writes the big-endian 16-bit words to consecutive addresses from 0.
// The processor is held in reset (cpu_hold) from the 0x55 command byte until
// the load completes successfully.
//
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   uart_rx    : asynchronous serial input, idle high, LSB first
//   imem       : instruction RAM write port (imem_wr_if.master)
//   cpu_hold   : processor held in reset while high
//   load_done  : sticky, last load completed
//   load_err   : sticky, last load aborted (framing, timeout, count, checksum)
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte (XOR of count_hi through the last data byte).
// -----------------------------------------------------------------------------
module imem_uart_loader #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_CLKS = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  imem_wr_if.master  imem,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int TMO_W        = $clog2(TIMEOUT_CLKS + 1);

  // ---------------------------------------------------------------------------
  // UART receive front end
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [1:0]       rx_sync_q;
  logic             rx_prev_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       nbit_q, nbit_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_s;
  logic             byte_valid;
  logic             frame_err;
  logic [7:0]       rx_byte;

  assign rx_s    = rx_sync_q[1];
  assign rx_byte = shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      bit_cnt_q  <= '0;
      nbit_q     <= '0;
      shift_q    <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], uart_rx};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      nbit_q     <= nbit_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    nbit_d     = nbit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = RX_START;
          bit_cnt_d  = '0;
        end
      end
      RX_START: begin
        // Mid-start re-sample: a high line means the edge was a glitch.
        if (bit_cnt_q == CNT_W'(HALF_BIT - 1)) begin
          bit_cnt_d  = '0;
          nbit_d     = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (nbit_q == 3'd7) rx_state_d = RX_STOP;
          else                nbit_d     = nbit_q + 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d  = '0;
          rx_state_d = RX_IDLE;
          if (rx_s) byte_valid = 1'b1;
          else      frame_err  = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame parser / RAM writer
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHK
`endif
  } ld_state_t;

  ld_state_t        state_q, state_d;
  logic [8:0]       addr_q, addr_d;
  logic [9:0]       remaining_q, remaining_d;
  logic [7:0]       cnt_hi_q, cnt_hi_d;
  logic [7:0]       hi_q, hi_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             we_q, we_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      count_w;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif

  assign count_w = {cnt_hi_q, rx_byte};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      cnt_hi_q    <= '0;
      hi_q        <= '0;
      tmo_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      cnt_hi_q    <= cnt_hi_d;
      hi_q        <= hi_d;
      tmo_q       <= tmo_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    cnt_hi_d    = cnt_hi_q;
    hi_d        = hi_q;
    tmo_d       = tmo_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    hold_d      = hold_q;
    done_d      = done_q;
    err_d       = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d       = chk_q;
`endif

    // Address advances the cycle after a strobe, but only when more words
    // follow, so the final address is held and a 512-word load never wraps.
    if (we_q && state_q == DATA_HI) addr_d = addr_q + 1'b1;

    if (state_q != IDLE) tmo_d = byte_valid ? '0 : tmo_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (byte_valid && rx_byte == 8'h55) begin
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          addr_d  = '0;
          tmo_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
          state_d = CNT_HI;
        end
      end
      CNT_HI: begin
        if (byte_valid) begin
          cnt_hi_d = rx_byte;
          state_d  = CNT_LO;
        end
      end
      CNT_LO: begin
        if (byte_valid) begin
          if (count_w == 16'd0 || count_w > 16'd512) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            remaining_d = count_w[9:0];
            state_d     = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (byte_valid) begin
          hi_d    = rx_byte;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
`ifndef IMEM_LOADER_CHECKSUM_EN
        // remaining_q reaches zero only on the cycle after the last strobe.
        if (remaining_q == 10'd0) begin
          done_d  = 1'b1;
          hold_d  = 1'b0;
          state_d = IDLE;
        end else
`endif
        if (byte_valid) begin
          we_d        = 1'b1;
          wdata_d     = {hi_q, rx_byte};
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == 10'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DATA_LO;
`endif
          end else begin
            state_d = DATA_HI;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (byte_valid) begin
          state_d = IDLE;
          if (rx_byte == chk_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
    if (byte_valid && (state_q == CNT_HI || state_q == CNT_LO ||
                       state_q == DATA_HI || state_q == DATA_LO))
      chk_d = chk_q ^ rx_byte;
`endif

    // In-frame aborts. A byte in the expiry cycle clears the timer instead.
    if (state_q != IDLE &&
        (frame_err || (!byte_valid && tmo_q == TMO_W'(TIMEOUT_CLKS - 1)))) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  assign imem.imem_we    = we_q;
  assign imem.imem_addr  = addr_q;
  assign imem.imem_wdata = wdata_q;
  assign cpu_hold        = hold_q;
  assign load_done       = done_q;
  assign load_err        = err_q;

endmodule
